// File: rtl/long_imul_mac_pkg.sv
// Shared constants for the iterative multiplier/accumulator: op codes,
// default operand width and controller states.
package long_imul_mac_pkg;

   localparam int unsigned CPU_REG_WIDTH = 32;

   localparam logic [1:0] MUL_OP_MUL  = 2'b00;
   localparam logic [1:0] MUL_OP_MADD = 2'b01;
   localparam logic [1:0] MUL_OP_MSUB = 2'b10;

   typedef enum logic [1:0] {
      IMUL_IDLE = 2'b00,
      IMUL_MUL  = 2'b01,
      IMUL_FIN  = 2'b10
   } imul_state_e;

endpackage

// File: rtl/long_imul_mac_imul_step.sv
// One radix-2^STEP shift-add step over unsigned magnitudes:
// next = {prod_hi + mc_abs*prod[STEP-1:0], prod_lo} >> STEP.
module imul_step #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned STEP  = 2
) (
   input  logic [2*WIDTH-1:0] prod,
   input  logic [WIDTH-1:0]   mc_abs,
   output logic [2*WIDTH-1:0] prod_next
);

   localparam int unsigned SW = WIDTH + STEP;

   logic [SW-1:0] sum;

   // Partial-product add kept WIDTH+STEP wide so no carry is lost before the shift
   always_comb begin
      sum       = SW'(prod[2*WIDTH-1:WIDTH]) + SW'(mc_abs) * SW'(prod[STEP-1:0]);
      prod_next = {sum, prod[WIDTH-1:STEP]};
   end

endmodule

// File: rtl/long_imul_mac.sv
// Iterative integer multiply / multiply-accumulate / multiply-subtract into
// a 2*WIDTH {HI,LO} result. Magnitudes are multiplied unsigned, STEP bits
// per cycle; sign and accumulate are applied in a single finalize cycle.
module long_imul_mac
   import long_imul_mac_pkg::*;
#(
   parameter int unsigned WIDTH = CPU_REG_WIDTH,
   parameter int unsigned STEP  = 2
) (
   input  logic                 clk,
   input  logic                 nrst,
   input  logic                 start,
   input  logic                 abort,
   input  logic                 signd,
   input  logic [1:0]           op,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   input  logic [2*WIDTH-1:0]   acc_in,
   output logic                 ready,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int unsigned NSTEP = WIDTH / STEP;
   localparam int unsigned CNT_W = $clog2(NSTEP + 1);

   imul_state_e          state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]     mc_abs_q, mc_abs_d;
   logic [2*WIDTH-1:0]   prod_q, prod_d;
   logic                 neg_q, neg_d;
   logic [1:0]           op_q, op_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [2*WIDTH-1:0]   product_q, product_d;
   logic                 done_q, done_d;

   logic [WIDTH-1:0]     mc_abs_in, mp_abs_in;
   logic [2*WIDTH-1:0]   step_prod;
   logic [2*WIDTH-1:0]   signed_prod;
   logic [2*WIDTH-1:0]   fin_result;

   imul_step #(
      .WIDTH (WIDTH),
      .STEP  (STEP)
   ) u_step (
      .prod      (prod_q),
      .mc_abs    (mc_abs_q),
      .prod_next (step_prod)
   );

   assign ready   = (state_q == IMUL_IDLE);
   assign done    = done_q;
   assign product = product_q;

   // Operand magnitudes from the live inputs (used only on the accepting edge)
   always_comb begin
      mc_abs_in = (signd && multiplicand[WIDTH-1]) ? -multiplicand : multiplicand;
      mp_abs_in = (signd && multiplier[WIDTH-1])   ? -multiplier   : multiplier;
   end

   // Finalize: restore sign, then apply accumulate/subtract modulo 2^(2*WIDTH)
   always_comb begin
      signed_prod = neg_q ? -prod_q : prod_q;
      case (op_q)
         MUL_OP_MADD: fin_result = acc_q + signed_prod;
         MUL_OP_MSUB: fin_result = acc_q - signed_prod;
         default:     fin_result = signed_prod;
      endcase
   end

   // Next-state and datapath control for IDLE -> MUL -> FIN
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mc_abs_d  = mc_abs_q;
      prod_d    = prod_q;
      neg_d     = neg_q;
      op_d      = op_q;
      acc_d     = acc_q;
      product_d = product_q;
      done_d    = 1'b0;
      case (state_q)
         IMUL_IDLE: begin
            if (start && !abort) begin
               mc_abs_d = mc_abs_in;
               neg_d    = signd && (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
               op_d     = op;
               acc_d    = acc_in;
               if (multiplicand == '0 || multiplier == '0) begin
                  prod_d  = '0;
                  cnt_d   = '0;
                  state_d = IMUL_FIN;
               end else begin
                  prod_d  = {{WIDTH{1'b0}}, mp_abs_in};
                  cnt_d   = CNT_W'(NSTEP);
                  state_d = IMUL_MUL;
               end
            end
         end
         IMUL_MUL: begin
            if (abort) begin
               cnt_d   = '0;
               state_d = IMUL_IDLE;
            end else begin
               prod_d = step_prod;
               cnt_d  = cnt_q - 1'b1;
               if (cnt_q == CNT_W'(1)) state_d = IMUL_FIN;
            end
         end
         IMUL_FIN: begin
            state_d = IMUL_IDLE;
            if (!abort) begin
               product_d = fin_result;
               done_d    = 1'b1;
            end
         end
         default: state_d = IMUL_IDLE;
      endcase
   end

   // State and datapath registers, asynchronously cleared
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q   <= IMUL_IDLE;
         cnt_q     <= '0;
         mc_abs_q  <= '0;
         prod_q    <= '0;
         neg_q     <= 1'b0;
         op_q      <= '0;
         acc_q     <= '0;
         product_q <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mc_abs_q  <= mc_abs_d;
         prod_q    <= prod_d;
         neg_q     <= neg_d;
         op_q      <= op_d;
         acc_q     <= acc_d;
         product_q <= product_d;
         done_q    <= done_d;
      end
   end

endmodule
